// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ack bus between the fetch sequencer (master) and imem (slave).
// Handshake: imem_req stays high with imem_addr stable until a cycle in which imem_ack is
// high; imem_rdata is consumed in that same cycle and the request drops at the next edge.
interface fetch_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles an outstanding fetch waits for ack; expired when the count reaches TIMEOUT.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  assign expired = (count_q == CW'(TIMEOUT));

  // Saturates at TIMEOUT so a stuck enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CW'(1);
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and imem fetch sequencer feeding decode, with branch redirects and fetch timeout.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect target -> misalign_err, ERR).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                redirect,
  input  logic [WIDTH-1:0]    redirect_base,
  input  logic [WIDTH-1:0]    redirect_imm,
  input  logic                stall,
  fetch_sequencer_if.master   imem,
  output logic                instr_valid,
  output logic [WIDTH-1:0]    instr,
  output logic [WIDTH-1:0]    instr_pc,
  output logic                timeout_err,
  output logic                misalign_err,
  output fetch_state_t        state_dbg
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] ipc_q, ipc_d;
  logic             pend_q, pend_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             terr_q, terr_d;
  logic             merr_q, merr_d;

  logic [WIDTH-1:0] target_raw;
  logic [WIDTH-1:0] target_pc;
  logic             misalign;
  logic             tmr_en;
  logic             tmr_expired;

  assign target_raw = redirect_base + redirect_imm;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_pc = target_raw;
  assign misalign  = redirect && (target_raw[1:0] != 2'b00);
`else
  assign target_pc = target_raw & ~WIDTH'(3);
  assign misalign  = 1'b0;
`endif

  // Timer runs only while a request is actually outstanding and unanswered.
  assign tmr_en = (state_q == FETCH) && req_q && !imem.imem_ack;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (!tmr_en),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    pend_d    = pend_q;
    req_d     = req_q;
    valid_d   = valid_q;
    terr_d    = terr_q;
    merr_d    = merr_q;

    unique case (state_q)
      IDLE: begin
        if (misalign) begin
          state_d = ERR;
          merr_d  = 1'b1;
        end else if (redirect) begin
          pc_d = target_pc;
        end else if (en) begin
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end

      FETCH: begin
        if (req_q) begin
          if (tmr_expired) begin
            state_d = ERR;
            req_d   = 1'b0;
            pend_d  = 1'b0;
            terr_d  = 1'b1;
          end else if (misalign) begin
            state_d = ERR;
            req_d   = 1'b0;
            pend_d  = 1'b0;
            merr_d  = 1'b1;
          end else if (imem.imem_ack) begin
            req_d = 1'b0;
            if (redirect) begin
              pc_d   = target_pc;
              pend_d = 1'b0;
            end else if (pend_q) begin
              pc_d   = pend_pc_q;
              pend_d = 1'b0;
            end else begin
              instr_d = imem.imem_rdata;
              ipc_d   = pc_q;
              valid_d = 1'b1;
              state_d = OUT;
            end
          end else if (redirect) begin
            // imem_addr must hold until ack, so the newest target waits here.
            pend_d    = 1'b1;
            pend_pc_d = target_pc;
          end
        end else begin
          // Gap cycle after a dropped word: nothing outstanding, pc may move freely.
          if (misalign) begin
            state_d = ERR;
            merr_d  = 1'b1;
          end else begin
            if (redirect) begin
              pc_d = target_pc;
            end
            if (en) begin
              req_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      OUT: begin
        if (misalign) begin
          state_d = ERR;
          valid_d = 1'b0;
          merr_d  = 1'b1;
        end else if (redirect || !stall) begin
          pc_d    = redirect ? target_pc : (pc_q + WIDTH'(INSTR_BYTES));
          valid_d = 1'b0;
          state_d = en ? FETCH : IDLE;
          req_d   = en;
        end
      end

      ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      instr_q   <= '0;
      ipc_q     <= '0;
      pend_q    <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      terr_q    <= 1'b0;
      merr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      terr_q    <= terr_d;
      merr_q    <= merr_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = valid_q;
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;
  assign timeout_err    = terr_q;
  assign misalign_err   = merr_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetch ordering, stall, redirects, timeout, wrap, alignment.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int W = 32;
  localparam int TMO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         redirect;
  logic [W-1:0] redirect_base;
  logic [W-1:0] redirect_imm;
  logic         stall;
  logic         instr_valid;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc;
  logic         timeout_err;
  logic         misalign_err;
  fetch_state_t state_dbg;

  fetch_sequencer_if #(.WIDTH(W)) imem_bus ();

  fetch_sequencer #(.WIDTH(W), .RESET_PC('0), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .redirect      (redirect),
    .redirect_base (redirect_base),
    .redirect_imm  (redirect_imm),
    .stall         (stall),
    .imem          (imem_bus),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .timeout_err   (timeout_err),
    .misalign_err  (misalign_err),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request and compare its address with the oldest expected fetch address.
  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!imem_bus.imem_req && n < budget) begin
      step();
      n++;
    end
    check("req_seen", W'(imem_bus.imem_req), 1);
    check("req_addr", imem_bus.imem_addr, exp_q.pop_front());
  endtask

  // Answer the current request after 'delay' cycles; expect the word to reach decode.
  task automatic do_ack(input int delay, input logic [W-1:0] data, input logic [W-1:0] addr);
    for (int i = 0; i < delay; i++) begin
      step();
      check("addr_hold", imem_bus.imem_addr, addr);
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = data;
    step();
    imem_bus.imem_ack   = 1'b0;
    check("valid_after_ack", W'(instr_valid), 1);
    check("instr", instr, data);
    check("instr_pc", instr_pc, addr);
    check("req_gap", W'(imem_bus.imem_req), 0);
  endtask

  task automatic pulse_redirect(input logic [W-1:0] base, input logic [W-1:0] imm);
    redirect      = 1'b1;
    redirect_base = base;
    redirect_imm  = imm;
    step();
    redirect      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b0; en = 1'b0; redirect = 1'b0; stall = 1'b0;
    redirect_base = '0; redirect_imm = '0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
    step();
    step();

    // reset state
    check("rst_state", W'(state_dbg), W'(IDLE));
    check("rst_req", W'(imem_bus.imem_req), 0);
    check("rst_addr", imem_bus.imem_addr, 0);
    check("rst_valid", W'(instr_valid), 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_terr", W'(timeout_err), 0);
    check("rst_merr", W'(misalign_err), 0);
    rst = 1'b1;

    // 1: sequential fetches 0x0, 0x4, 0x8 with ack two cycles after req
    en = 1'b1;
    step();
    exp_q.push_back(32'h0);
    wait_req(4);
    do_ack(2, 32'hA000_0000, 32'h0);
    exp_q.push_back(32'h4);
    wait_req(4);
    do_ack(2, 32'hA000_0004, 32'h4);
    exp_q.push_back(32'h8);
    wait_req(4);

    // 2: stall holds OUT with instr_pc 0x8
    stall = 1'b1;
    do_ack(2, 32'hA000_0008, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", W'(instr_valid), 1);
      check("stall_instr", instr, 32'hA000_0008);
      check("stall_instr_pc", instr_pc, 32'h8);
      check("stall_pc", imem_bus.imem_addr, 32'h8);
      check("stall_no_req", W'(imem_bus.imem_req), 0);
    end
    stall = 1'b0;
    step();
    exp_q.push_back(32'hC);
    wait_req(0);

    // 3: redirect while FETCH awaits ack; target 0x10 + -0x10 = 0x0
    pulse_redirect(32'h10, 32'hFFFF_FFF0);
    check("redir_addr_hold0", imem_bus.imem_addr, 32'hC);
    step();
    check("redir_addr_hold1", imem_bus.imem_addr, 32'hC);
    check("redir_req_hold", W'(imem_bus.imem_req), 1);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_bus.imem_ack = 1'b0;
    check("drop_valid", W'(instr_valid), 0);
    check("drop_req_gap", W'(imem_bus.imem_req), 0);
    step();
    check("drop_valid2", W'(instr_valid), 0);
    exp_q.push_back(32'h0);
    wait_req(0);

    // 4: redirect in OUT under stall; target 0x28
    do_ack(2, 32'hB000_0000, 32'h0);
    stall = 1'b1;
    pulse_redirect(32'h20, 32'h8);
    check("out_redir_valid", W'(instr_valid), 0);
    exp_q.push_back(32'h28);
    wait_req(0);
    stall = 1'b0;

    // 5: no ack -> timeout after TMO+1 request cycles
    cyc = 1;
    while (!timeout_err && cyc < 40) begin
      step();
      if (!timeout_err) cyc++;
    end
    check("tmo_cycles", W'(cyc), W'(TMO + 1));
    check("tmo_err", W'(timeout_err), 1);
    check("tmo_req", W'(imem_bus.imem_req), 0);
    check("tmo_valid", W'(instr_valid), 0);
    check("tmo_state", W'(state_dbg), W'(ERR));
    pulse_redirect(32'h100, 32'h0);
    step();
    check("err_hold_terr", W'(timeout_err), 1);
    check("err_hold_req", W'(imem_bus.imem_req), 0);
    check("err_hold_addr", imem_bus.imem_addr, 32'h28);
    check("err_hold_state", W'(state_dbg), W'(ERR));
    #2;
    en = 1'b0;
    rst = 1'b0;
    #1;
    check("async_rst_terr", W'(timeout_err), 0);
    check("async_rst_state", W'(state_dbg), W'(IDLE));
    check("async_rst_addr", imem_bus.imem_addr, 0);
    step();
    rst = 1'b1;

    // 6: pc wrap from 0xFFFFFFFC
    pulse_redirect(32'hFFFF_FFF0, 32'hC);
    check("idle_redir_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    check("idle_redir_state", W'(state_dbg), W'(IDLE));
    en = 1'b1;
    step();
    exp_q.push_back(32'hFFFF_FFFC);
    wait_req(2);
    do_ack(1, 32'hC000_0000, 32'hFFFF_FFFC);
    step();
    exp_q.push_back(32'h0);
    wait_req(0);

    // alignment: target 0x0 + 0x2
    pulse_redirect(32'h0, 32'h2);
`ifdef FETCH_ALIGN_CHECK_EN
    check("align_merr", W'(misalign_err), 1);
    check("align_state", W'(state_dbg), W'(ERR));
    check("align_req", W'(imem_bus.imem_req), 0);
`else
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h1234_5678;
    step();
    imem_bus.imem_ack = 1'b0;
    check("align_drop_valid", W'(instr_valid), 0);
    step();
    exp_q.push_back(32'h0);
    wait_req(0);
    check("align_merr", W'(misalign_err), 0);

    // en low parks in IDLE after the current transaction
    en = 1'b0;
    do_ack(0, 32'hD000_0000, 32'h0);
    step();
    check("park_state", W'(state_dbg), W'(IDLE));
    check("park_req", W'(imem_bus.imem_req), 0);
    check("park_pc", imem_bus.imem_addr, 32'h4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
